// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the E stage; owns HI/LO.
// Multi-cycle ops compute their result on the accepting edge into pending
// registers and commit after a fixed busy count.
// Optional feature macro: MDU_MADD_EN enables madd/maddu (codes 9/10).
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_md_use,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI = 4'd5, OP_MTLO  = 4'd6, OP_MFHI = 4'd7,
    OP_MFLO  = 4'd8,  OP_MADD = 4'd9, OP_MADDU = 4'd10
  } md_op_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic               op_mul, op_div, op_long, mul_signed, div_signed;
  logic [2*WIDTH-1:0] prod, mul_res;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, divisor, q_mag, r_mag, quot, rem;
`ifdef MDU_MADD_EN
  logic               op_madd;
`endif

  // Op decode and the combinational multiply/divide datapath.
  always_comb begin
`ifdef MDU_MADD_EN
    op_madd    = (md_op == OP_MADD) || (md_op == OP_MADDU);
    op_mul     = (md_op == OP_MULT) || (md_op == OP_MULTU) || op_madd;
    mul_signed = (md_op == OP_MULT) || (md_op == OP_MADD);
`else
    op_mul     = (md_op == OP_MULT) || (md_op == OP_MULTU);
    mul_signed = (md_op == OP_MULT);
`endif
    op_div     = (md_op == OP_DIV) || (md_op == OP_DIVU);
    op_long    = op_mul || op_div;
    div_signed = (md_op == OP_DIV);

    // Sign-extending to 2*WIDTH makes the truncated product the signed product.
    if (mul_signed)
      prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    else
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`ifdef MDU_MADD_EN
    mul_res = op_madd ? ({hi_q, lo_q} + prod) : prod;
`else
    mul_res = prod;
`endif

    // Divide on magnitudes, then restore signs; MIN/-1 falls out as lo=MIN, hi=0.
    a_neg   = div_signed && a[WIDTH-1];
    b_neg   = div_signed && b[WIDTH-1];
    abs_a   = a_neg ? (~a + 1'b1) : a;
    abs_b   = b_neg ? (~b + 1'b1) : b;
    divisor = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    q_mag   = abs_a / divisor;
    r_mag   = abs_a % divisor;
    quot    = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem     = a_neg ? (~r_mag + 1'b1) : r_mag;
  end

  // Next-state logic: accept in IDLE, count down, commit pending result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_mul) begin
            state_d                = S_MUL;
            cnt_d                  = CNT_W'(MULT_CYCLES);
            busy_d                 = 1'b1;
            {pend_hi_d, pend_lo_d} = mul_res;
            pend_wr_d              = 1'b1;
          end else if (op_div) begin
            state_d   = S_DIV;
            cnt_d     = CNT_W'(DIV_CYCLES);
            busy_d    = 1'b1;
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_wr_d = (b != '0);
          end else if (md_op == OP_MTHI) begin
            hi_d = a;
          end else if (md_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and architectural register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Combinational read port and D-stage stall request.
  always_comb begin
    case (md_op)
      OP_MFHI: rd_data = hi_q;
      OP_MFLO: rd_data = lo_q;
      default: rd_data = '0;
    endcase
    stall_req = d_md_use && (busy_q || (start && op_long));
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector table plus multi-cycle sequences for mdu_ctrl.
module tb_mdu_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n, start, d_md_use;
  logic [3:0]   md_op;
  logic [W-1:0] a, b;
  logic         busy, stall_req, done;
  logic [W-1:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op), .a(a), .b(b),
    .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo),
    .rd_data(rd_data), .done(done)
  );

  typedef struct {
    logic         st;
    logic [3:0]   op;
    logic [W-1:0] va, vb;
    logic         du;
    logic         e_busy, e_stall, e_done;
    logic [W-1:0] e_hi, e_lo, e_rd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic add(input logic st, input logic [3:0] op, input logic [W-1:0] va,
                     input logic [W-1:0] vb, input logic du, input logic eb,
                     input logic es, input logic ed, input logic [W-1:0] eh,
                     input logic [W-1:0] el, input logic [W-1:0] er);
    vec_t v;
    v.st = st; v.op = op; v.va = va; v.vb = vb; v.du = du;
    v.e_busy = eb; v.e_stall = es; v.e_done = ed;
    v.e_hi = eh; v.e_lo = el; v.e_rd = er;
    vq.push_back(v);
  endtask

  // One cycle: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic drive(input logic st, input logic [3:0] op, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic du);
    @(negedge clk);
    start = st; md_op = op; a = va; b = vb; d_md_use = du;
    #1;
  endtask

  // Issue a multi-cycle op, check n busy cycles, then the committed result.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic du, input int n,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    drive(1'b1, op, va, vb, du);
    chk({nm, ".issue_stall"}, stall_req, du);
    chk({nm, ".issue_busy"}, busy, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'd0, '0, '0, du);
      chk($sformatf("%s.busy%0d", nm, i), busy, 1'b1);
      chk($sformatf("%s.stall%0d", nm, i), stall_req, du);
      chk($sformatf("%s.done%0d", nm, i), done, 1'b0);
    end
    drive(1'b0, 4'd0, '0, '0, du);
    chk({nm, ".end_busy"}, busy, 1'b0);
    chk({nm, ".end_stall"}, stall_req, 1'b0);
    chk({nm, ".done"}, done, 1'b1);
    chk({nm, ".hi"}, hi, ehi);
    chk({nm, ".lo"}, lo, elo);
    drive(1'b0, 4'd0, '0, '0, 1'b0);
    chk({nm, ".done_drop"}, done, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; md_op = '0; a = '0; b = '0; d_md_use = 1'b0;
    // st op a b du | busy stall done hi lo rd
    add(0, 0, 0, 0, 0,                     0, 0, 0, 32'h0, 32'h0, 32'h0);
    add(1, 5, 32'h12345678, 0, 0,          0, 0, 0, 32'h0, 32'h0, 32'h0);
    add(1, 7, 0, 0, 1,                     0, 0, 0, 32'h12345678, 32'h0, 32'h12345678);
    add(1, 6, 32'hAA, 0, 0,                0, 0, 0, 32'h12345678, 32'h0, 32'h0);
    add(1, 8, 0, 0, 0,                     0, 0, 0, 32'h12345678, 32'hAA, 32'hAA);
    add(1, 1, 32'hFFFFFFFD, 7, 1,          0, 1, 0, 32'h12345678, 32'hAA, 32'h0);
    add(0, 0, 0, 0, 1,                     1, 1, 0, 32'h12345678, 32'hAA, 32'h0);
    add(1, 5, 32'hDEADBEEF, 0, 1,          1, 1, 0, 32'h12345678, 32'hAA, 32'h0);
    add(1, 3, 100, 3, 1,                   1, 1, 0, 32'h12345678, 32'hAA, 32'h0);
    add(0, 7, 0, 0, 0,                     1, 0, 0, 32'h12345678, 32'hAA, 32'h12345678);
    add(0, 0, 0, 0, 1,                     1, 1, 0, 32'h12345678, 32'hAA, 32'h0);
    add(0, 8, 0, 0, 1,                     0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFEB);
    add(0, 0, 0, 0, 0,                     0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0);
    add(1, 15, 32'h55, 32'h66, 1,          0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0);
    add(0, 0, 0, 0, 0,                     0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0);

    #12;
    chk("reset.busy", busy, 1'b0);
    chk("reset.hi", hi, '0);
    chk("reset.lo", lo, '0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].op, vq[i].va, vq[i].vb, vq[i].du);
      chk($sformatf("v%0d.busy", i), busy, vq[i].e_busy);
      chk($sformatf("v%0d.stall", i), stall_req, vq[i].e_stall);
      chk($sformatf("v%0d.done", i), done, vq[i].e_done);
      chk($sformatf("v%0d.hi", i), hi, vq[i].e_hi);
      chk($sformatf("v%0d.lo", i), lo, vq[i].e_lo);
      chk($sformatf("v%0d.rd", i), rd_data, vq[i].e_rd);
    end

    run_op("div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_by0", 4'd4, 32'd7, 32'd0, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h0, 32'h80000000);
    run_op("div_7_m2", 4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 10, 32'h1, 32'hFFFFFFFD);
    run_op("divu_max_2", 4'd4, 32'hFFFFFFFF, 32'd2, 1'b0, 10, 32'h1, 32'h7FFFFFFF);
    run_op("multu_mflo", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5, 32'hFFFFFFFE, 32'h00000001);

    drive(1'b1, 4'd5, 32'h0, '0, 1'b0);
    drive(1'b1, 4'd6, 32'hFFFFFFFF, '0, 1'b0);
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b1, 5, 32'h1, 32'h0);
    run_op("madd", 4'd9, 32'hFFFFFFFF, 32'd1, 1'b0, 5, 32'h0, 32'hFFFFFFFF);
`else
    drive(1'b1, 4'd10, 32'd1, 32'd1, 1'b1);
    chk("maddu_off.stall", stall_req, 1'b0);
    drive(1'b0, 4'd0, '0, '0, 1'b0);
    chk("maddu_off.busy", busy, 1'b0);
    chk("maddu_off.hi", hi, 32'h0);
    chk("maddu_off.lo", lo, 32'hFFFFFFFF);
    drive(1'b0, 4'd0, '0, '0, 1'b0);
    chk("maddu_off.done", done, 1'b0);
`endif

    // Reset arriving mid-divide while the count sits at 4.
    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 4'd0, '0, '0, 1'b0);
    chk("rstmid.busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.hi", hi, '0);
    chk("rstmid.lo", lo, '0);
    chk("rstmid.done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'd0, '0, '0, 1'b0);
      chk($sformatf("rstmid.after_done%0d", i), done, 1'b0);
      chk($sformatf("rstmid.after_busy%0d", i), busy, 1'b0);
      chk($sformatf("rstmid.after_lo%0d", i), lo, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
